// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants: datapath width, register index width and the
// hardwired-zero register index used by decode, hazard and writeback logic.
package wb_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned N_RD_PORTS = 2;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

endpackage : wb_regfile_pkg

// File: rtl/wb_mux.sv
// Writeback result select: load data or ALU result. Kept separate so the
// EX-stage forwarding muxes can reuse the same selection logic.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic [DATA_W-1:0] result_o
);

  assign result_o = mem_to_reg_i ? load_data_i : alu_out_i;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Writeback stage plus 2**ADDR_W x DATA_W architectural register file with
// two combinational read ports and same-cycle write-to-read bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              regWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [DATA_W-1:0] AluOutW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [ADDR_W-1:0] ReadReg1D,
  input  logic [ADDR_W-1:0] ReadReg2D,
  output logic [DATA_W-1:0] ReadData1D,
  output logic [DATA_W-1:0] ReadData2D,
  output logic [DATA_W-1:0] ResultW
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;
  logic [ADDR_W-1:0] rd_idx  [N_RD_PORTS];
  logic [DATA_W-1:0] rd_data [N_RD_PORTS];

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .mem_to_reg_i (MemtoRegW),
    .load_data_i  (readDataW),
    .alu_out_i    (AluOutW),
    .result_o     (ResultW)
  );

  // A write only counts when not in reset and not aimed at register 0; the
  // same qualifier gates the bypass so reset suppresses forwarding too.
  assign wr_en = regWriteW && !clr && (WriteRegW != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[WriteRegW] <= ResultW;
    end
  end

  assign rd_idx[0] = ReadReg1D;
  assign rd_idx[1] = ReadReg2D;

  generate
    for (genvar gi = 0; gi < N_RD_PORTS; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = regs_q[rd_idx[gi]];
        if (rd_idx[gi] == ZERO_IDX) begin
          rd_data[gi] = '0;
        end else if (wr_en && (WriteRegW == rd_idx[gi])) begin
          rd_data[gi] = ResultW;
        end
      end
    end
  endgenerate

  assign ReadData1D = rd_data[0];
  assign ReadData2D = rd_data[1];

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: hand-computed expectations checked with
// immediate assertions at each step.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        clr;
  logic        regWriteW;
  logic        MemtoRegW;
  logic [31:0] readDataW;
  logic [31:0] AluOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  ReadReg1D;
  logic [4:0]  ReadReg2D;
  logic [31:0] ReadData1D;
  logic [31:0] ReadData2D;
  logic [31:0] ResultW;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .regWriteW  (regWriteW),
    .MemtoRegW  (MemtoRegW),
    .readDataW  (readDataW),
    .AluOutW    (AluOutW),
    .WriteRegW  (WriteRegW),
    .ReadReg1D  (ReadReg1D),
    .ReadReg2D  (ReadReg2D),
    .ReadData1D (ReadData1D),
    .ReadData2D (ReadData2D),
    .ResultW    (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("assertion %s", tag);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  // Present W-stage inputs, let combinational paths settle.
  task automatic drive(input logic c, input logic we, input logic m2r,
                       input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    clr = c; regWriteW = we; MemtoRegW = m2r; readDataW = ld; AluOutW = alu;
    WriteRegW = wr; ReadReg1D = r1; ReadReg2D = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    check("reset_r1", ReadData1D, 32'h0);
    check("reset_r31", ReadData2D, 32'h0);

    // Preload r1, r2, r5
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h11111111, 5'd1, 5'd0, 5'd0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'h22222222, 32'h0, 5'd2, 5'd0, 5'd0); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h55555555, 5'd5, 5'd0, 5'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    check("preload_r1", ReadData1D, 32'h11111111);
    check("preload_r2", ReadData2D, 32'h22222222);

    // Reset clears preloaded registers; during clr the stored values still show
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd1);
    check("clr_cycle_r5", ReadData1D, 32'h55555555);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    check("post_clr_r1", ReadData1D, 32'h0);
    check("post_clr_r2", ReadData2D, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    check("post_clr_r5", ReadData1D, 32'h0);

    // Basic ALU write to r8
    drive(1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h12345678, 5'd8, 5'd0, 5'd0);
    check("alu_resultw", ResultW, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
    check("r8_stored", ReadData1D, 32'h12345678);

    // Load select with same-cycle bypass on port 2
    drive(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000001, 5'd9, 5'd0, 5'd9);
    check("load_resultw", ResultW, 32'hDEADBEEF);
    check("bypass_p2_r9", ReadData2D, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    check("r9_stored", ReadData1D, 32'hDEADBEEF);

    // Zero register is never written and never bypassed
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    check("zero_resultw", ResultW, 32'hFFFFFFFF);
    check("zero_during_p1", ReadData1D, 32'h0);
    check("zero_during_p2", ReadData2D, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check("zero_after_p1", ReadData1D, 32'h0);
    check("zero_after_p2", ReadData2D, 32'h0);

    // Write disabled: no bypass, no commit
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA5555, 5'd10, 5'd10, 5'd0);
    check("wdis_resultw", ResultW, 32'hAAAA5555);
    check("wdis_no_bypass", ReadData1D, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    check("wdis_r10", ReadData1D, 32'h0);

    // Both ports on the same register
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
    check("same_reg_p1", ReadData1D, 32'h12345678);
    check("same_reg_p2", ReadData2D, 32'h12345678);

    // Back-to-back writes to r12, bypass on both ports
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h000000A1, 5'd12, 5'd12, 5'd12);
    check("b2b_first_p1", ReadData1D, 32'h000000A1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h000000B2, 5'd12, 5'd12, 5'd12);
    check("b2b_second_p1", ReadData1D, 32'h000000B2);
    check("b2b_second_p2", ReadData2D, 32'h000000B2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd0);
    check("b2b_stored", ReadData1D, 32'h000000B2);

    // Reset vs write collision on r5
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000055, 5'd5, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd5, 5'd5, 5'd8);
    check("coll_during_r5", ReadData1D, 32'h00000055);
    check("coll_during_r8", ReadData2D, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd8);
    check("coll_after_r5", ReadData1D, 32'h0);
    check("coll_after_r8", ReadData2D, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_regfile
